// File: rtl/hcms_frame_ctrl.sv
// Frame controller for an HCMS-29xx style dot-matrix display: power-up reset,
// control-word setup, then streams a column buffer to a byte-wide serial shifter.
module hcms_frame_ctrl #(
  parameter int          NUM_COLS     = 20,
  parameter int          RESET_CYCLES = 16,
  parameter logic [1:0]  PEAK_CURRENT = 2'b11
) (
  input  logic       i_CLK,
  input  logic       i_reset,
  input  logic       i_col_we,
  input  logic [4:0] i_col_addr,
  input  logic [7:0] i_col_data,
  input  logic [3:0] i_brightness,
  input  logic       i_update,
  output logic [7:0] o_byte,
  output logic       o_byte_load,
  input  logic       i_shift_done,
  output logic       o_cmd,
  output logic       o_disp_reset,
  output logic       o_busy,
  output logic       o_frame_done
);

  typedef enum logic [2:0] {S_RST_HOLD, S_CW1, S_CW0, S_IDLE, S_DATA, S_LATCH} state_t;

  localparam logic [5:0]  NC       = NUM_COLS[5:0];
  localparam logic [4:0]  LAST_COL = 5'(NUM_COLS - 1);
  localparam logic [15:0] RST_LAST = 16'(RESET_CYCLES - 1);

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic [7:0]  byte_q, byte_d;
  logic [4:0]  col_q, col_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic [3:0]  last_bri_q, last_bri_d;
  logic        frame_pend_q, frame_pend_d;
  logic        cw_pend_q, cw_pend_d;

  logic [7:0]  col_buf [NUM_COLS];
  logic        wr_ok, sending, byte_done, enter_cw0, enter_data;

  assign wr_ok     = i_col_we && ({1'b0, i_col_addr} < NC);
  assign sending   = (state_q == S_CW1) || (state_q == S_CW0) || (state_q == S_DATA);
  // ack_q marks the second half of the handshake: load dropped, waiting for done to fall
  assign byte_done = sending && ack_q && !i_shift_done;

  always_ff @(posedge i_CLK) begin
    if (wr_ok) col_buf[i_col_addr] <= i_col_data;
  end

  always_comb begin
    state_d      = state_q;
    ack_d        = ack_q;
    byte_d       = byte_q;
    col_d        = col_q;
    rcnt_d       = rcnt_q;
    last_bri_d   = last_bri_q;
    frame_pend_d = frame_pend_q;
    cw_pend_d    = cw_pend_q | (i_brightness != last_bri_q);
    enter_cw0    = 1'b0;
    enter_data   = 1'b0;

    if (sending && !ack_q && i_shift_done) ack_d = 1'b1;
    if (byte_done)                         ack_d = 1'b0;

    unique case (state_q)
      S_RST_HOLD: begin
        rcnt_d = rcnt_q + 16'd1;
        if (rcnt_q == RST_LAST) begin
          state_d = S_CW1;
          byte_d  = 8'h81;
          rcnt_d  = '0;
        end
      end
      S_CW1:   if (byte_done) enter_cw0 = 1'b1;
      S_CW0:   if (byte_done) state_d = S_IDLE;
      S_IDLE: begin
        if (cw_pend_q)         enter_cw0  = 1'b1;
        else if (frame_pend_q) enter_data = 1'b1;
      end
      S_DATA: begin
        if (byte_done) begin
          if (col_q == LAST_COL) begin
            state_d = S_LATCH;
            col_d   = '0;
          end else begin
            col_d  = col_q + 5'd1;
            byte_d = col_buf[col_q + 5'd1];
          end
        end
      end
      S_LATCH: state_d = S_IDLE;
      default: state_d = S_RST_HOLD;
    endcase

    if (enter_cw0) begin
      state_d    = S_CW0;
      byte_d     = {2'b01, PEAK_CURRENT, i_brightness};
      last_bri_d = i_brightness;
      cw_pend_d  = 1'b0;
      ack_d      = 1'b0;
    end
    if (enter_data) begin
      state_d      = S_DATA;
      byte_d       = col_buf[0];
      col_d        = '0;
      ack_d        = 1'b0;
      frame_pend_d = 1'b0;
    end
    // a request landing on the DATA entry cycle must survive into the next frame
    if (wr_ok || i_update) frame_pend_d = 1'b1;
  end

  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_RST_HOLD;
      ack_q        <= 1'b0;
      byte_q       <= '0;
      col_q        <= '0;
      rcnt_q       <= '0;
      last_bri_q   <= '0;
      frame_pend_q <= 1'b1;
      cw_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      byte_q       <= byte_d;
      col_q        <= col_d;
      rcnt_q       <= rcnt_d;
      last_bri_q   <= last_bri_d;
      frame_pend_q <= frame_pend_d;
      cw_pend_q    <= cw_pend_d;
    end
  end

  assign o_byte       = byte_q;
  assign o_byte_load  = sending && !ack_q;
  assign o_cmd        = (state_q == S_CW1) || (state_q == S_CW0);
  assign o_disp_reset = (state_q == S_RST_HOLD);
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = (state_q == S_LATCH);

endmodule

// File: doc/hcms_frame_ctrl.md
HCMS_FRAME_CTRL -- requirements
Module: hcms_frame_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_COLS, default 20, meaning column bytes per frame (4 chars x 5 columns).
REQ-002 The block SHALL have parameter RESET_CYCLES, default 16, meaning i_CLK cycles o_disp_reset is held after reset release.
REQ-003 The block SHALL have parameter PEAK_CURRENT, default 2'b11, meaning control word 0 bits [5:4].
REQ-004 The block SHALL have port i_CLK, input, 1, meaning the single clock; all logic uses the rising edge.
REQ-005 The block SHALL have port i_reset, input, 1, meaning asynchronous active-high reset.
REQ-006 The block SHALL have port i_col_we, input, 1, meaning column-buffer write strobe.
REQ-007 The block SHALL have port i_col_addr, input, 5, meaning column index 0..NUM_COLS-1.
REQ-008 The block SHALL have port i_col_data, input, 8, meaning column pixel byte (bit0 = top row).
REQ-009 The block SHALL have port i_brightness, input, 4, meaning PWM brightness for control word 0 [3:0].
REQ-010 The block SHALL have port i_update, input, 1, meaning single-cycle request to refresh the frame.
REQ-011 The block SHALL have port o_byte, output, 8, meaning byte presented to the serial shifter.
REQ-012 The block SHALL have port o_byte_load, output, 1, meaning load request to the shifter.
REQ-013 The block SHALL have port i_shift_done, input, 1, meaning shifter finished the current byte.
REQ-014 The block SHALL have port o_cmd, output, 1, meaning register select (1 = control, 0 = dot data).
REQ-015 The block SHALL have port o_disp_reset, output, 1, meaning display reset (active high).
REQ-016 The block SHALL have port o_busy, output, 1, meaning high in every state except IDLE.
REQ-017 The block SHALL have port o_frame_done, output, 1, meaning one-cycle pulse after a frame is latched.

Function
REQ-018 The block SHALL implement states RST_HOLD, CW1, CW0, IDLE, DATA and LATCH.
REQ-019 RST_HOLD SHALL hold o_disp_reset=1 for RESET_CYCLES cycles, then go to CW1.
REQ-020 CW1 SHALL send 8'h81 with o_cmd=1, then go to CW0.
REQ-021 CW0 SHALL send {1'b0,1'b1,PEAK_CURRENT,brightness}, with brightness sampled on entry to CW0, then go to IDLE.
REQ-022 Each byte transfer SHALL be a 4-phase handshake: o_byte and o_cmd stable and o_byte_load=1 until i_shift_done=1, then o_byte_load=0 until i_shift_done=0, then advance.
REQ-023 o_byte SHALL NOT change while o_byte_load=1 or i_shift_done=1.
REQ-024 Column writes SHALL store into a NUM_COLS x 8 buffer in the cycle of i_col_we; writes with i_col_addr>=NUM_COLS SHALL be ignored.
REQ-025 A frame_pending flag SHALL be set by i_update or by any accepted column write, and cleared on entry to DATA.
REQ-026 A cw_pending flag SHALL be set when i_brightness differs from the last value sent, and cleared on entry to CW0.
REQ-027 From IDLE, cw_pending SHALL take priority (go to CW0 and return to IDLE); otherwise frame_pending SHALL cause a transition to DATA.
REQ-028 DATA SHALL send buffer columns 0..NUM_COLS-1 in order with o_cmd=0, using a column counter that wraps to 0 after NUM_COLS-1, then go to LATCH.
REQ-029 Writes during DATA SHALL update the buffer immediately and set frame_pending, so the next frame follows automatically.
REQ-030 LATCH SHALL last one cycle, pulse o_frame_done, and go to IDLE.
REQ-031 i_update during a non-IDLE state SHALL be retained via frame_pending and SHALL never be lost.
REQ-032 A simultaneous i_update and column write SHALL set frame_pending once (one frame).

Reset
REQ-033 Asserting i_reset SHALL immediately force state RST_HOLD, o_disp_reset=1, o_byte_load=0, o_byte=0, o_cmd=0, o_frame_done=0, o_busy=1, clear counters and flags, set frame_pending=1 and set cw_pending=0; buffer contents are undefined.
REQ-034 Reset asserted mid-transfer SHALL abandon the byte, and the sequence SHALL restart from RST_HOLD after release.

Verification
REQ-035 The bench SHALL check reset release with brightness=4'h1 -> o_disp_reset high for 16 cycles, then bytes 8'h81 (cmd=1) and 8'h71 (cmd=0 flag off, o_cmd=1), then 20 data bytes (o_cmd=0) and one o_frame_done pulse.
REQ-036 The bench SHALL check that writing columns 0..19 with 8'h7E,8'h11,8'h11,8'h11,8'h7E,... followed by i_update produces exactly those 20 bytes in order.
REQ-037 The bench SHALL check that changing brightness to 4'hF while in IDLE with a frame pending causes 8'h7F to be sent (o_cmd=1) before the data frame.
REQ-038 The bench SHALL check that a write to column 3 during column 10 of DATA causes a second complete frame to follow that contains the new byte.
REQ-039 The bench SHALL check that a shifter delaying i_shift_done by 0..50 random cycles holds o_byte stable and keeps o_byte_load high throughout.
REQ-040 The bench SHALL check that i_reset pulsed during DATA column 7 drops o_byte_load asynchronously and restarts the sequence from RST_HOLD.
